// File: rtl/ysyx_23060061_ifu_pkg.sv
// rtl/ysyx_23060061_ifu_pkg.sv - shared state encoding and constants for the instruction fetch unit
package ysyx_23060061_ifu_pkg;

  typedef enum logic [1:0] {
    IFU_REQ  = 2'd0,
    IFU_WAIT = 2'd1,
    IFU_HOLD = 2'd2,
    IFU_HALT = 2'd3
  } ifu_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_23060061_ifu_pc.sv
// rtl/ysyx_23060061_ifu_pc.sv - PC register with next-PC select and drop flag
// YSYX_23060061_IFU_ALIGN_CHECK_EN keeps misaligned redirect targets intact instead of masking them.
module ysyx_23060061_ifu_pc
  import ysyx_23060061_ifu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redir,
  input  logic            inc,
  input  logic            set_drop,
  input  logic            clr_drop,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_next,
  output logic            drop
);

  logic [XLEN-1:0] target;

`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
  assign target = redirect_pc;
`else
  assign target = redirect_pc & ~XLEN'(3);
`endif

  always_comb begin
    pc_next = pc;
    if (redir) begin
      pc_next = target;
    end else if (inc) begin
      pc_next = pc + XLEN'(4);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc   <= RESET_PC;
      drop <= 1'b0;
    end else begin
      pc <= pc_next;
      if (set_drop) begin
        drop <= 1'b1;
      end else if (clr_drop) begin
        drop <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ysyx_23060061_ifu.sv
// rtl/ysyx_23060061_ifu.sv - instruction fetch unit: one outstanding word read, valid/ready to decode
// YSYX_23060061_IFU_ALIGN_CHECK_EN turns a misaligned redirect into a faulting nop without a memory request.
module ysyx_23060061_ifu
  import ysyx_23060061_ifu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
);

  ifu_state_t      state;
  logic            halt_pend;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] req_addr;
  logic            drop;
  logic            redir;
  logic            inc;
  logic            set_drop;
  logic            clr_drop;
  logic            misaligned;
  logic            req_v;
  logic            hs;

`ifdef YSYX_23060061_IFU_ALIGN_CHECK_EN
  assign misaligned = (pc[1:0] != 2'b00) && !drop;
`else
  assign misaligned = 1'b0;
`endif

  assign req_v         = (state == IFU_REQ) && !misaligned;
  assign hs            = (state == IFU_HOLD) && inst_ready;
  assign mem_req_valid = req_v && !rst;
  assign mem_req_addr  = mem_req_valid ? req_addr : '0;
  assign inst_valid    = (state == IFU_HOLD);
  assign halted        = (state == IFU_HALT);

  // In HOLD, drop marks that pc already holds a late redirect target.
  always_comb begin
    redir    = 1'b0;
    inc      = 1'b0;
    set_drop = 1'b0;
    clr_drop = 1'b0;
    case (state)
      IFU_REQ: begin
        redir    = redirect_valid;
        set_drop = redirect_valid && req_v;
      end
      IFU_WAIT: begin
        redir    = redirect_valid;
        set_drop = redirect_valid && !mem_rsp_valid;
        clr_drop = mem_rsp_valid;
      end
      IFU_HOLD: begin
        redir    = redirect_valid;
        inc      = hs && !redirect_valid && !drop;
        set_drop = !hs && redirect_valid;
        clr_drop = hs;
      end
      default: ;
    endcase
  end

  ysyx_23060061_ifu_pc #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .redir       (redir),
    .inc         (inc),
    .set_drop    (set_drop),
    .clr_drop    (clr_drop),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .pc_next     (pc_next),
    .drop        (drop)
  );

  // The request address is frozen while presented, so late redirects only move pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IFU_REQ;
      halt_pend  <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
      inst_fault <= 1'b0;
      req_addr   <= RESET_PC & ~XLEN'(3);
    end else begin
      if (!req_v) begin
        req_addr <= pc_next & ~XLEN'(3);
      end
      case (state)
        IFU_REQ: begin
          if (misaligned) begin
            if (halt || halt_pend) begin
              state <= IFU_HALT;
            end else if (!redirect_valid) begin
              inst       <= NOP_INST;
              inst_pc    <= pc;
              inst_fault <= 1'b1;
              state      <= IFU_HOLD;
            end
          end else begin
            if (halt) halt_pend <= 1'b1;
            if (mem_req_ready) state <= IFU_WAIT;
          end
        end
        IFU_WAIT: begin
          if (mem_rsp_valid) begin
            if (halt || halt_pend) begin
              state <= IFU_HALT;
            end else if (drop || redirect_valid) begin
              state <= IFU_REQ;
            end else begin
              inst       <= mem_rsp_err ? NOP_INST : mem_rsp_data;
              inst_pc    <= pc;
              inst_fault <= mem_rsp_err;
              state      <= IFU_HOLD;
            end
          end else if (halt) begin
            halt_pend <= 1'b1;
          end
        end
        IFU_HOLD: begin
          if (inst_ready) begin
            state <= (halt || halt_pend) ? IFU_HALT : IFU_REQ;
          end else if (halt) begin
            halt_pend <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Memory may only answer while a fetch is outstanding.
  assert property (@(posedge clk) disable iff (rst) mem_rsp_valid |-> state == IFU_WAIT);

endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
// tb/tb_ysyx_23060061_ifu.sv - scoreboard bench for the instruction fetch unit
module tb_ysyx_23060061_ifu;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        halted;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] addr_q[$];
  exp_t        inst_q[$];

  logic        ready_en = 1'b1;
  int          rsp_delay = 1;
  logic [31:0] err_addr = 32'hffff_fff0;

  always #5 clk = ~clk;

  ysyx_23060061_ifu dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_fault     (inst_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .halted         (halted)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h8000_0000: mem_word = 32'h0010_0093;
      32'h8000_0004: mem_word = 32'h0020_0113;
      32'h8000_0008: mem_word = 32'h0030_0193;
      default:       mem_word = {a[11:0], 20'h00013};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_fetch(input logic [31:0] a, input logic [31:0] w, input logic f);
    exp_t e;
    e.word  = w;
    e.pc    = a;
    e.fault = f;
    addr_q.push_back(a);
    inst_q.push_back(e);
  endtask

  // Wait for a presented instruction, then accept it for one cycle with optional side inputs.
  task automatic consume(input logic rv, input logic [31:0] rpc, input logic hlt, input logic rdy);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (inst_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL inst_valid_timeout: got none want inst_valid within 100 cycles");
    end
    @(posedge clk); #1;
    inst_ready     = 1'b1;
    redirect_valid = rv;
    redirect_pc    = rpc;
    halt           = hlt;
    ready_en       = rdy;
    @(posedge clk); #1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    halt           = 1'b0;
  endtask

  // Memory: accepts while ready_en, answers rsp_delay cycles after the accept.
  initial begin
    logic [31:0] pend_addr;
    int          cnt;
    cnt           = 0;
    pend_addr     = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    mem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        pend_addr = mem_req_addr;
        cnt       = rsp_delay;
      end
      @(posedge clk); #2;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(pend_addr);
          mem_rsp_err   = (pend_addr == err_addr);
        end
      end
      mem_req_ready = ready_en;
    end
  end

  // Monitor: every accepted request and every consumed instruction is checked against the queues.
  initial begin
    logic [31:0] ea;
    exp_t        ei;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (mem_req_valid && mem_req_ready) begin
          if (addr_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL req_unexpected: got addr %h want no request", mem_req_addr);
          end else begin
            ea = addr_q.pop_front();
            chk("req_addr", mem_req_addr, ea);
          end
        end
        if (inst_valid && inst_ready) begin
          if (inst_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL inst_unexpected: got inst %h pc %h want none", inst, inst_pc);
          end else begin
            ei = inst_q.pop_front();
            chk("inst", inst, ei.word);
            chk("inst_pc", inst_pc, ei.pc);
            chk("inst_fault", {31'b0, inst_fault}, {31'b0, ei.fault});
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   busy;
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halt           = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);

    // Sequential fetch after reset release
    expect_fetch(32'h8000_0000, 32'h0010_0093, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_fetch(32'h8000_0004, 32'h0020_0113, 1'b0);
    consume(1'b0, '0, 1'b0, 1'b1);
    expect_fetch(32'h8000_0008, 32'h0030_0193, 1'b0);
    consume(1'b0, '0, 1'b0, 1'b1);

    // Redirect during the decode handshake replaces pc+4
    err_addr = 32'h8000_0044;
    expect_fetch(32'h8000_0040, 32'h0400_0013, 1'b0);
    consume(1'b1, 32'h8000_0040, 1'b0, 1'b1);
    expect_fetch(32'h8000_0044, 32'h0000_0013, 1'b1);
    consume(1'b0, '0, 1'b0, 1'b1);

    // Access fault, then a late redirect while the request is stalled
    addr_q.push_back(32'h8000_0048);
    expect_fetch(32'h8000_0100, 32'h1000_0013, 1'b0);
    consume(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req_valid", {31'b0, mem_req_valid}, 32'd1);
      chk("stall_req_addr", mem_req_addr, 32'h8000_0048);
      @(posedge clk); #1;
      redirect_valid = (i == 1);
      redirect_pc    = 32'h8000_0100;
    end
    redirect_valid = 1'b0;
    ready_en       = 1'b1;
    addr_q.push_back(32'h8000_0104);
    consume(1'b0, '0, 1'b0, 1'b1);

    // Reset while waiting; the stale response lands during reset
    rsp_delay = 3;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_valid && mem_req_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no accept want accept within 20 cycles");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("wait_rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("wait_rst_inst", inst, 32'd0);
    chk("wait_rst_inst_pc", inst_pc, 32'd0);
    rsp_delay = 1;
    expect_fetch(32'h8000_0000, 32'h0010_0093, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    expect_fetch(32'h8000_0004, 32'h0020_0113, 1'b0);
    consume(1'b0, '0, 1'b0, 1'b1);
    expect_fetch(32'h8000_0008, 32'h0030_0193, 1'b0);
    consume(1'b0, '0, 1'b0, 1'b1);

    // Halt with the handshake at 0x80000008
    consume(1'b0, '0, 1'b1, 1'b1);
    @(negedge clk);
    chk("halted", {31'b0, halted}, 32'd1);
    chk("halt_inst_valid", {31'b0, inst_valid}, 32'd0);
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_valid || inst_valid) busy++;
    end
    chk("halt_quiet_cycles", busy, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("unhalt_rst", {31'b0, halted}, 32'd0);
    expect_fetch(32'h8000_0000, 32'h0010_0093, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    consume(1'b0, '0, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    chk("addr_q_left", addr_q.size(), 32'd0);
    chk("inst_q_left", inst_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
